universal_shift_register: RTL and testbench
===========================================

Name: universal_shift_register

Overview:
- Parametrised successor to the team's parallel-load register.
- Adds serial in/out, left/right logical, arithmetic and rotate shifts, and clear/hold modes.
- Multi-bit shifts run one bit per cycle under a start/busy/done handshake.
- Sits in datapath and serialiser logic wherever a loadable, shiftable word register is needed.

Parameters:
- DATA_WIDTH, 8: register width in bits (≥2).
- CNT_WIDTH, $clog2(DATA_WIDTH+1): width of shift_amt and the internal shift counter.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-low.
- start  input  1  request a new operation; sampled only in IDLE.
- mode  input  3  operation code, captured on accept.
- shift_amt  input  CNT_WIDTH  number of single-bit shifts, captured on accept.
- parallel_in  input  DATA_WIDTH  load data.
- serial_in  input  1  fill bit for SHL/SHR; sampled on every shift edge.
- parallel_out  output  DATA_WIDTH  register contents.
- serial_out  output  1  registered copy of the bit that left the register on the most recent shift.
- busy  output  1  high while in SHIFT.
- done  output  1  single-cycle completion pulse.

Behaviour:
- Reset (async, reset=0): parallel_out=0, serial_out=0, busy=0, done=0, state=IDLE, counter=0, captured mode/amount cleared.
- Reset applies immediately, including mid-SHIFT; the operation in flight is abandoned with no done pulse.
- Mode encoding:
  - 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ASR, 7 CLEAR.
- States: IDLE, SHIFT.
- Accept: a rising edge with state=IDLE and start=1.
- Single-edge operations (HOLD, LOAD, CLEAR, and any shift mode with shift_amt=0):
  - HOLD and shift_amt=0 leave parallel_out unchanged.
  - LOAD sets parallel_out=parallel_in at the accept edge.
  - CLEAR sets parallel_out=0 at the accept edge.
  - done=1 for exactly the following cycle; state stays IDLE; busy stays 0.
- Shift modes with shift_amt>0:
  - The accept edge captures mode and N=min(shift_amt, DATA_WIDTH), then enters SHIFT with counter=N and busy=1.
  - parallel_out does not change on the accept edge.
  - Each subsequent edge in SHIFT performs one single-bit step and decrements the counter.
  - The edge that takes the counter from 1 to 0 performs the final step, sets done=1 for one cycle, busy=0, and returns to IDLE.
  - busy is high for exactly N cycles; done is asserted in the cycle after the N-th step edge.
- Single-bit step, with r=parallel_out:
  - SHL: r={r[W-2:0],serial_in}, serial_out=r[W-1].
  - SHR: r={serial_in,r[W-1:1]}, serial_out=r[0].
  - ROL: r={r[W-2:0],r[W-1]}, serial_out=r[W-1].
  - ROR: r={r[0],r[W-1:1]}, serial_out=r[0].
  - ASR: r={r[W-1],r[W-1:1]}, serial_out=r[0].
- serial_out changes only on shift edges and holds otherwise.
- start while busy=1 is ignored: no capture, no queueing.
- start in the cycle where done=1 is legal; state is IDLE, so back-to-back operations are allowed.
- mode, shift_amt and parallel_in are don't-care outside the accept edge.
- Any change to them during SHIFT has no effect.
- shift_amt>DATA_WIDTH is clamped to DATA_WIDTH; a rotate by DATA_WIDTH returns the original word.

Decomposition:
- Package usr_pkg:
  - mode_e enum (3-bit, encodings above).
  - state_e enum {IDLE, SHIFT}.
- Sub-module usr_shift_step: combinational single-bit shifter.
  - Inputs: r, mode, serial_in.
  - Outputs: next r, out bit.
- The top level holds the FSM, counter, captured mode and output registers.

Test Plan:
- Reset with reset=0 during random stimulus -> parallel_out=0x00, serial_out=0, busy=0, done=0; release, then idle start=0 -> all stay 0.
- LOAD 0xA5 -> parallel_out=0xA5 after the accept edge; done high exactly one cycle; busy never high.
- From 0xA5, SHL shift_amt=3, serial_in=1 -> parallel_out steps 0x4B, 0x97, 0x2F; serial_out 1, 0, 1; busy for 3 cycles; done on the 4th cycle after accept.
- From 0x90, ASR shift_amt=2 -> 0xC8, then 0xE4; from 0x3C, ROR shift_amt=9 -> clamped to 8; busy 8 cycles; final 0x3C.
- During a SHL of amount 4, pulse start with mode=LOAD, parallel_in=0xFF -> ignored, shift completes normally; then shift_amt=0 with mode=SHR -> done next cycle, parallel_out unchanged.
- Assert reset two cycles into a SHR of amount 5 -> parallel_out=0x00, busy=0 immediately, no done pulse; next accepted LOAD 0x11 works normally.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register:
// operation codes and controller states.
package usr_pkg;

   typedef enum logic [2:0] {
      M_HOLD  = 3'd0,
      M_LOAD  = 3'd1,
      M_SHL   = 3'd2,
      M_SHR   = 3'd3,
      M_ROL   = 3'd4,
      M_ROR   = 3'd5,
      M_ASR   = 3'd6,
      M_CLEAR = 3'd7
   } mode_e;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

endpackage

// File: rtl/usr_shift_step.sv
// One single-bit shift step: next word plus the bit that
// falls off the end. Non-shift modes pass the word through.
module usr_shift_step
   import usr_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] r,
   input  mode_e                 mode,
   input  logic                  serial_in,
   output logic [DATA_WIDTH-1:0] r_next,
   output logic                  out_bit
);

   localparam int W = DATA_WIDTH;

   always_comb begin
      r_next  = r;
      out_bit = 1'b0;
      unique case (mode)
         M_SHL: begin
            r_next  = {r[W-2:0], serial_in};
            out_bit = r[W-1];
         end
         M_SHR: begin
            r_next  = {serial_in, r[W-1:1]};
            out_bit = r[0];
         end
         M_ROL: begin
            r_next  = {r[W-2:0], r[W-1]};
            out_bit = r[W-1];
         end
         M_ROR: begin
            r_next  = {r[0], r[W-1:1]};
            out_bit = r[0];
         end
         M_ASR: begin
            r_next  = {r[W-1], r[W-1:1]};
            out_bit = r[0];
         end
         default: begin
            r_next  = r;
            out_bit = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/universal_shift_register.sv
// Loadable word register with serial I/O and multi-cycle
// shift/rotate operations under a start/busy/done handshake.
module universal_shift_register
   import usr_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [2:0]            mode,
   input  logic [CNT_WIDTH-1:0]  shift_amt,
   input  logic [DATA_WIDTH-1:0] parallel_in,
   input  logic                  serial_in,
   output logic [DATA_WIDTH-1:0] parallel_out,
   output logic                  serial_out,
   output logic                  busy,
   output logic                  done
);

   localparam logic [CNT_WIDTH-1:0] MAX_AMT = CNT_WIDTH'(DATA_WIDTH);
   localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

   state_e                state;
   mode_e                 mode_q;
   mode_e                 mode_in;
   logic [CNT_WIDTH-1:0]  cnt;
   logic [CNT_WIDTH-1:0]  amt_n;
   logic [DATA_WIDTH-1:0] step_r;
   logic                  step_bit;

   assign mode_in = mode_e'(mode);
   assign amt_n   = (shift_amt > MAX_AMT) ? MAX_AMT : shift_amt;

   usr_shift_step #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_step (
      .r         (parallel_out),
      .mode      (mode_q),
      .serial_in (serial_in),
      .r_next    (step_r),
      .out_bit   (step_bit)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         mode_q       <= M_HOLD;
         cnt          <= '0;
         parallel_out <= '0;
         serial_out   <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  unique case (mode_in)
                     M_HOLD: done <= 1'b1;
                     M_LOAD: begin
                        parallel_out <= parallel_in;
                        done         <= 1'b1;
                     end
                     M_CLEAR: begin
                        parallel_out <= '0;
                        done         <= 1'b1;
                     end
                     default: begin
                        // zero-length shifts finish like a hold
                        if (amt_n == '0) begin
                           done <= 1'b1;
                        end else begin
                           mode_q <= mode_in;
                           cnt    <= amt_n;
                           busy   <= 1'b1;
                           state  <= SHIFT;
                        end
                     end
                  endcase
               end
            end
            SHIFT: begin
               parallel_out <= step_r;
               serial_out   <= step_bit;
               cnt          <= cnt - ONE;
               if (cnt == ONE) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register: directed vector table,
// mid-shift reset sequence and random run against a word model.
module tb_universal_shift_register;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [2:0] mode = 3'd0;
   logic [3:0] shift_amt = 4'd0;
   logic [7:0] parallel_in = 8'd0;
   logic       serial_in = 1'b0;
   logic [7:0] parallel_out;
   logic       serial_out;
   logic       busy;
   logic       done;

   int total = 0;
   int bad = 0;

   universal_shift_register dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .mode         (mode),
      .shift_amt    (shift_amt),
      .parallel_in  (parallel_in),
      .serial_in    (serial_in),
      .parallel_out (parallel_out),
      .serial_out   (serial_out),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   // reference model: word as integer, remaining shift count
   int m_r = 0;
   int m_left = 0;
   int m_mode = 0;
   int m_so = 0;
   int m_busy = 0;
   int m_done = 0;

   task automatic model_zero();
      m_r = 0; m_left = 0; m_mode = 0;
      m_so = 0; m_busy = 0; m_done = 0;
   endtask

   task automatic model_edge();
      int s;
      int n;
      if (!reset) begin
         model_zero();
         return;
      end
      s = int'(serial_in);
      if (m_busy != 0) begin
         case (m_mode)
            2: begin m_so = m_r / 128; m_r = (m_r * 2 + s) % 256; end
            3: begin m_so = m_r % 2; m_r = m_r / 2 + s * 128; end
            4: begin m_so = m_r / 128; m_r = (m_r * 2 + m_r / 128) % 256; end
            5: begin m_so = m_r % 2; m_r = m_r / 2 + (m_r % 2) * 128; end
            default: begin m_so = m_r % 2; m_r = m_r / 2 + (m_r / 128) * 128; end
         endcase
         m_left = m_left - 1;
         m_busy = (m_left > 0) ? 1 : 0;
         m_done = (m_left == 0) ? 1 : 0;
      end else begin
         m_done = 0;
         if (start) begin
            n = (int'(shift_amt) > 8) ? 8 : int'(shift_amt);
            if (mode == 3'd1) m_r = int'(parallel_in);
            if (mode == 3'd7) m_r = 0;
            if (mode == 3'd0 || mode == 3'd1 || mode == 3'd7 || n == 0) begin
               m_done = 1;
            end else begin
               m_mode = int'(mode);
               m_left = n;
               m_busy = 1;
            end
         end
      end
   endtask

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, exp, $time);
      end
   endtask

   task automatic check_model(string tag);
      chk({tag, ".out"}, 32'(parallel_out), 32'(m_r));
      chk({tag, ".so"}, 32'(serial_out), 32'(m_so));
      chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
      chk({tag, ".done"}, 32'(done), 32'(m_done));
   endtask

   task automatic cycle(string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_model(tag);
   endtask

   task automatic drive(logic st, logic [2:0] md, logic [3:0] am,
                        logic [7:0] pi, logic si);
      start = st; mode = md; shift_amt = am;
      parallel_in = pi; serial_in = si;
   endtask

   typedef struct {
      logic       st;
      logic [2:0] md;
      logic [3:0] am;
      logic [7:0] pi;
      logic       si;
      logic [7:0] eo;
      logic       eso;
      logic       eb;
      logic       ed;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic st, logic [2:0] md, logic [3:0] am,
                               logic [7:0] pi, logic si, logic [7:0] eo,
                               logic eso, logic eb, logic ed);
      vec_t v;
      v.st = st; v.md = md; v.am = am; v.pi = pi; v.si = si;
      v.eo = eo; v.eso = eso; v.eb = eb; v.ed = ed;
      return v;
   endfunction

   initial begin
      // LOAD, then SHL 3 with serial_in=1
      tbl.push_back(mk(1, 1, 0, 8'hA5, 0, 8'hA5, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'hA5, 0, 0, 0));
      tbl.push_back(mk(1, 2, 3, 8'h00, 1, 8'hA5, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 1, 8'h4B, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 1, 8'h97, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 1, 8'h2F, 1, 0, 1));
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'h2F, 1, 0, 0));
      // ASR 2 from 0x90
      tbl.push_back(mk(1, 1, 0, 8'h90, 0, 8'h90, 1, 0, 1));
      tbl.push_back(mk(1, 6, 2, 8'h00, 0, 8'h90, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'hC8, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'hE4, 0, 0, 1));
      // ROR 9 clamps to 8 and returns the original word
      tbl.push_back(mk(1, 1, 0, 8'h3C, 0, 8'h3C, 0, 0, 1));
      tbl.push_back(mk(1, 5, 9, 8'h00, 0, 8'h3C, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'h1E, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'h0F, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'h87, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'hC3, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'hE1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'hF0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'h78, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'h3C, 0, 0, 1));
      // SHL 4 with an ignored LOAD request mid-shift
      tbl.push_back(mk(1, 2, 4, 8'h00, 0, 8'h3C, 0, 1, 0));
      tbl.push_back(mk(1, 1, 0, 8'hFF, 0, 8'h78, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'hF0, 0, 1, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'hE0, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'hC0, 1, 0, 1));
      // zero-length SHR, then CLEAR back-to-back with its done
      tbl.push_back(mk(1, 3, 0, 8'h00, 1, 8'hC0, 1, 0, 1));
      tbl.push_back(mk(1, 7, 0, 8'h00, 0, 8'h00, 1, 0, 1));
      tbl.push_back(mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 0, 0));

      // reset held with random inputs
      model_zero();
      for (int i = 0; i < 3; i++) begin
         drive(1'($urandom), 3'($urandom), 4'($urandom), 8'($urandom),
               1'($urandom));
         cycle("rst");
      end
      chk("rst.out", 32'(parallel_out), 32'h0);
      chk("rst.busy", 32'(busy), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      drive(0, 0, 0, 8'h00, 0);
      for (int i = 0; i < 2; i++) begin
         cycle("idle");
         chk("idle.out", 32'(parallel_out), 32'h0);
         chk("idle.done", 32'(done), 32'h0);
      end

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].st, tbl[i].md, tbl[i].am, tbl[i].pi, tbl[i].si);
         cycle($sformatf("vec%0d", i));
         chk($sformatf("vec%0d.out", i), 32'(parallel_out), 32'(tbl[i].eo));
         chk($sformatf("vec%0d.so", i), 32'(serial_out), 32'(tbl[i].eso));
         chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(tbl[i].eb));
         chk($sformatf("vec%0d.done", i), 32'(done), 32'(tbl[i].ed));
      end

      // reset two edges into SHR 5 abandons the operation
      drive(1, 1, 0, 8'hB6, 0);
      cycle("mr.load");
      drive(1, 3, 5, 8'h00, 1);
      cycle("mr.acc");
      drive(0, 0, 0, 8'h00, 1);
      cycle("mr.s1");
      cycle("mr.s2");
      chk("mr.pre", 32'(parallel_out), 32'hED);
      #2;
      reset = 1'b0;
      #1;
      model_zero();
      chk("mr.out", 32'(parallel_out), 32'h0);
      chk("mr.busy", 32'(busy), 32'h0);
      chk("mr.done", 32'(done), 32'h0);
      for (int i = 0; i < 2; i++) begin
         cycle("mr.hold");
         chk("mr.nodone", 32'(done), 32'h0);
      end
      @(negedge clk);
      reset = 1'b1;
      drive(1, 1, 0, 8'h11, 0);
      cycle("mr.reload");
      chk("mr.reload.out", 32'(parallel_out), 32'h11);
      chk("mr.reload.done", 32'(done), 32'h1);
      drive(0, 0, 0, 8'h00, 0);
      cycle("mr.after");

      // random run, occasional asynchronous reset pulses
      for (int i = 0; i < 1500; i++) begin
         drive(1'($urandom_range(0, 2) != 0), 3'($urandom),
               4'($urandom_range(0, 10)), 8'($urandom), 1'($urandom));
         if ($urandom_range(0, 199) == 0) begin
            #2;
            reset = 1'b0;
            #1;
            model_zero();
            check_model("rnd.arst");
            @(negedge clk);
            reset = 1'b1;
         end
         cycle("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
